johnson_phase_monitor: RTL
==========================

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive legal transitions required to enter LOCKED (range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port q, input, 4: Johnson counter state from the upstream 4-bit Johnson counter (q[0] fed by ~q[3]).
REQ-005 SHALL have port adv, input, 1: 1 = counter expected to advance this cycle, 0 = counter expected to hold.
REQ-006 SHALL have port clr_err, input, 1: synchronous clear of err_count and exit from FAULT.
REQ-007 SHALL have port phase, output, 8: one-hot decode of the last sampled q.
REQ-008 SHALL have port phase_idx, output, 3: binary index 0..7 of the last sampled q.
REQ-009 SHALL have port valid, output, 1: last sampled q is one of the 8 legal Johnson codes.
REQ-010 SHALL have port locked, output, 1: FSM is in LOCKED.
REQ-011 SHALL have port err, output, 1: single-cycle pulse on any detected sequence error.
REQ-012 SHALL have port err_count, output, 8: saturating count of sequence errors.

Function
REQ-013 SHALL treat the legal codes and indices as 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7; all other 8 codes are illegal.
REQ-014 SHALL register q into q_prev each rising edge, with a prev_ok flag set after the first post-reset sample.
REQ-015 SHALL register phase, phase_idx, and valid from q at each edge, giving 1-cycle latency. For illegal q: phase=0, phase_idx=0, valid=0.
REQ-016 SHALL define a legal transition as follows: adv=1 requires idx(q) = (idx(q_prev)+1) mod 8, so 1000->0000 wraps; adv=0 requires q == q_prev.
REQ-017 SHALL define a sequence error as prev_ok=1 and either an illegal q or an illegal transition. The first sample after reset is never an error.
REQ-018 SHALL assert err for exactly one cycle, registered, in the cycle after each erroneous sample. Back-to-back errors give continuous err.
REQ-019 SHALL increment err_count by 1 per error and saturate at 255.
REQ-020 SHALL implement FSM states IDLE, ACQUIRE, LOCKED, FAULT with a 4-bit good-transition counter good_cnt.
REQ-021 SHALL transition from IDLE to ACQUIRE on the first sample after reset with a legal q; an illegal q stays in IDLE.
REQ-022 SHALL, in ACQUIRE, increment good_cnt on each legal transition, go to LOCKED when good_cnt reaches LOCK_CNT, and reset good_cnt to 0 on an error while staying in ACQUIRE.
REQ-023 SHALL go from LOCKED to FAULT on any error; locked then deasserts in the same cycle err asserts.
REQ-024 SHALL, in FAULT, hold until clr_err=1, then go to ACQUIRE with good_cnt=0 (subject to REQ-030).
REQ-025 SHALL, when clr_err=1, zero err_count on that edge. If an error occurs on the same edge, clr wins, err still pulses, and err_count=0.
REQ-026 SHALL keep clr_err=1 outside FAULT from changing the FSM state.

Reset
REQ-027 SHALL, on reset=0, immediately force: phase=0, phase_idx=0, valid=0, locked=0, err=0, err_count=0, FSM=IDLE, good_cnt=0, prev_ok=0, q_prev=0000.
REQ-028 SHALL abandon any in-progress acquisition or FAULT when reset asserts mid-operation. After deassertion, behaviour restarts per REQ-021.
REQ-029 SHALL require reset deassertion to be synchronised externally; the block only guarantees asynchronous assertion.

Configuration
REQ-030 SHALL provide macro JOHNSON_PHASE_MONITOR_AUTORECOVER_EN. When defined, FAULT goes to ACQUIRE automatically after 2 consecutive legal transitions, and clr_err still also exits. When undefined, FAULT is sticky until clr_err per REQ-024.

Verification
REQ-031 SHALL cover basic lock: reset release, adv=1, legal sequence from 0000 for 10 cycles -> no err, locked=1 on the 4th edge after first sample (LOCK_CNT=3), phase walks 0x01,0x02,...,0x80,0x01.
REQ-032 SHALL cover wrap and hold: locked, q=1000 then adv=0 with q held at 1000 for 3 cycles, then adv=1 with q=0000 -> no err, phase_idx 7,7,7,7,0, locked stays 1.
REQ-033 SHALL cover illegal code: locked, inject q=0101 -> valid=0, phase=0, err pulses 1 cycle, err_count=1, locked=0, FSM=FAULT; with the macro undefined it stays FAULT until clr_err.
REQ-034 SHALL cover skip error: locked at q=0011, next q=1111 with adv=1 -> err=1, err_count increments, FSM=FAULT.
REQ-035 SHALL cover saturation and clear: 300 forced errors -> err_count=255; clr_err=1 coincident with an error -> err=1, err_count=0.
REQ-036 SHALL cover reset mid-operation: assert reset while in ACQUIRE with good_cnt=2 -> all outputs zero immediately; the first post-reset sample of q=0110 keeps the FSM in IDLE with no err.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
//-----------------------------------------------------------------------------
// johnson_phase_monitor
//
// Watches the state of an upstream 4-bit Johnson counter (q[0] fed by ~q[3])
// and reports the decoded phase, sequence errors and a lock indication.
//
// Every rising edge of clk samples q. From that sample the block registers:
//   - the one-hot phase, binary phase index and a "legal code" flag,
//   - a one-cycle err pulse when the sample breaks the expected sequence,
//   - a saturating error counter,
//   - the lock FSM (IDLE -> ACQUIRE -> LOCKED -> FAULT).
// All outputs change together, one cycle after the sample they describe.
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset (deassertion must be
//                      synchronised to clk outside this block)
//   q          in   4  Johnson counter state
//   adv        in   1  1 = counter should advance this cycle, 0 = hold
//   clr_err    in   1  synchronous clear of err_count, leaves FAULT
//   phase      out  8  one-hot phase of the last sample (0 if illegal)
//   phase_idx  out  3  phase index 0..7 of the last sample (0 if illegal)
//   valid      out  1  last sample was a legal Johnson code
//   locked     out  1  FSM is in LOCKED
//   err        out  1  pulse: last sample was a sequence error
//   err_count  out  8  saturating sequence-error count
//
// Parameter
//   LOCK_CNT   consecutive legal transitions needed to reach LOCKED (1..15)
//
// Build option
//   JOHNSON_PHASE_MONITOR_AUTORECOVER_EN
//       defined   : FAULT also returns to ACQUIRE by itself after two
//                   consecutive legal transitions (clr_err still works).
//       undefined : FAULT is left only through clr_err.
//-----------------------------------------------------------------------------
module johnson_phase_monitor #(
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] q,
    input  logic       adv,
    input  logic       clr_err,
    output logic [7:0] phase,
    output logic [2:0] phase_idx,
    output logic       valid,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // Returns {legal, index} for a 4-bit Johnson code.
    function automatic logic [3:0] jc_decode(input logic [3:0] code);
        logic [3:0] r;
        case (code)
            4'b0000: r = {1'b1, 3'd0};
            4'b0001: r = {1'b1, 3'd1};
            4'b0011: r = {1'b1, 3'd2};
            4'b0111: r = {1'b1, 3'd3};
            4'b1111: r = {1'b1, 3'd4};
            4'b1110: r = {1'b1, 3'd5};
            4'b1100: r = {1'b1, 3'd6};
            4'b1000: r = {1'b1, 3'd7};
            default: r = {1'b0, 3'd0};
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0] q_prev_q,    q_prev_d;
    logic       prev_ok_q,   prev_ok_d;
    logic [7:0] phase_q,     phase_d;
    logic [2:0] phase_idx_q, phase_idx_d;
    logic       valid_q,     valid_d;
    logic       locked_q,    locked_d;
    logic       err_q,       err_d;
    logic [7:0] err_count_q, err_count_d;
    state_t     state_q,     state_d;
    logic [3:0] good_cnt_q,  good_cnt_d;

    // ------------------------------------------------------------------
    // Decode of the current and previous samples
    // ------------------------------------------------------------------
    logic       q_legal;
    logic [2:0] q_idx;
    logic       prev_legal;
    logic [2:0] prev_idx;
    logic       trans_ok;
    logic       seq_err;

    always_comb begin
        {q_legal, q_idx}       = jc_decode(q);
        {prev_legal, prev_idx} = jc_decode(q_prev_q);
    end

    // A transition is only good if both ends are legal codes; an illegal
    // previous sample has no defined successor. The 3-bit add wraps 7 -> 0.
    always_comb begin
        trans_ok = 1'b0;
        if (q_legal && prev_legal) begin
            if (adv) begin
                trans_ok = (q_idx == (prev_idx + 3'd1));
            end else begin
                trans_ok = (q == q_prev_q);
            end
        end
    end

    // The first sample after reset has nothing to compare against.
    assign seq_err = prev_ok_q && !trans_ok;

    // ------------------------------------------------------------------
    // One-hot phase decode
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_phase
            assign phase_d[gi] = q_legal && (q_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        phase_idx_d = q_legal ? q_idx : 3'd0;
        valid_d     = q_legal;
        q_prev_d    = q;
        prev_ok_d   = 1'b1;
        err_d       = seq_err;
    end

    // ------------------------------------------------------------------
    // Saturating error counter; a clear on the same edge as an error wins.
    // ------------------------------------------------------------------
    always_comb begin
        err_count_d = err_count_q;
        if (clr_err) begin
            err_count_d = 8'd0;
        end else if (seq_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Leave IDLE on the first legal code seen after reset.
                if (q_legal) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = 4'd0;
                end
            end
            ST_ACQUIRE: begin
                if (seq_err) begin
                    good_cnt_d = 4'd0;
                end else if (trans_ok) begin
                    if ((good_cnt_q + 4'd1) == LOCK_CNT_L) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = 4'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (seq_err) begin
                    state_d    = ST_FAULT;
                    good_cnt_d = 4'd0;
                end
            end
            ST_FAULT: begin
                if (clr_err) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = 4'd0;
                end
`ifdef JOHNSON_PHASE_MONITOR_AUTORECOVER_EN
                // good_cnt doubles as the recovery run length here.
                else if (seq_err) begin
                    good_cnt_d = 4'd0;
                end else if (trans_ok) begin
                    if (good_cnt_q == 4'd1) begin
                        state_d    = ST_ACQUIRE;
                        good_cnt_d = 4'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                    end
                end
`else
                else begin
                    good_cnt_d = 4'd0;
                end
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                good_cnt_d = 4'd0;
            end
        endcase
    end

    // locked is registered from the next state so it lines up with err.
    always_comb begin
        locked_d = (state_d == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_prev_q    <= 4'b0000;
            prev_ok_q   <= 1'b0;
            phase_q     <= 8'd0;
            phase_idx_q <= 3'd0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            state_q     <= ST_IDLE;
            good_cnt_q  <= 4'd0;
        end else begin
            q_prev_q    <= q_prev_d;
            prev_ok_q   <= prev_ok_d;
            phase_q     <= phase_d;
            phase_idx_q <= phase_idx_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
        end
    end

    assign phase     = phase_q;
    assign phase_idx = phase_idx_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
